// File: rtl/data_capture_fifo_if.sv
// data_capture_fifo_if: write/read handshake and status bundle for data_capture_fifo
interface data_capture_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 8);
  logic enable;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] out;
  logic out_valid;
  logic out_ready;
  logic full;
  logic empty;
  logic [$clog2(DEPTH):0] count;
  logic [7:0] drop_cnt;
  logic overflow;
  modport master(output enable, data, out_ready, input out, out_valid, full, empty, count, drop_cnt, overflow);
  modport slave(input enable, data, out_ready, output out, out_valid, full, empty, count, drop_cnt, overflow);
endinterface

// File: rtl/data_capture_fifo.sv
// data_capture_fifo: show-ahead FIFO with write-drop accounting and overflow pulse
module data_capture_fifo #(parameter int WIDTH = 8, parameter int DEPTH = 8) (
  input logic clk,
  input logic rst,
  data_capture_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [7:0] drops;
  logic ovf, pop, push, rej, is_empty, is_full;
  assign is_empty = cnt == '0;
  assign is_full = cnt == FULL_CNT;
  assign pop = !is_empty && bus.out_ready;
  // a pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign push = bus.enable && (!is_full || pop);
  assign rej = bus.enable && !push;
  always_ff @(posedge clk) if (push) mem[wp] <= bus.data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      drops <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
      drops <= (rej && drops != 8'hff) ? drops + 8'd1 : drops;
      ovf <= rej;
    end
  assign bus.out = is_empty ? '0 : mem[rp];
  assign bus.out_valid = !is_empty;
  assign bus.full = is_full;
  assign bus.empty = is_empty;
  assign bus.count = cnt;
  assign bus.drop_cnt = drops;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_data_capture_fifo.sv
// tb_data_capture_fifo: random and directed stimulus against a queue-based reference model
module tb_data_capture_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] q[$];
  int exp_drop = 0;
  bit exp_ovf = 1'b0;
  data_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
  data_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("out", 32'(bus.out), q.size() != 0 ? 32'(q[0]) : 32'd0);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
  endtask
  task automatic model_reset();
    q.delete();
    exp_drop = 0;
    exp_ovf = 1'b0;
  endtask
  task automatic step(input bit en, input logic [WIDTH-1:0] d, input bit rdy);
    bit pop, push;
    bus.enable = en;
    bus.data = d;
    bus.out_ready = rdy;
    pop = q.size() != 0 && rdy;
    push = en && (q.size() < DEPTH || pop);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    exp_ovf = en && !push;
    if (exp_ovf && exp_drop != 255) exp_drop++;
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.data = '0;
    bus.out_ready = 1'b0;
    #1;
    check_all();
    do_reset();
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk("req031_count", 32'(bus.count), 32'd3);
    chk("req031_out", 32'(bus.out), 32'h11);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
    chk("req032_full", 32'(bus.full), 32'd1);
    step(1, 8'hAA, 0);
    chk("req032_ovf", 32'(bus.overflow), 32'd1);
    chk("req032_drop", 32'(bus.drop_cnt), 32'd1);
    step(0, 8'h00, 0);
    chk("req032_ovf_once", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("req032_drain", 32'(bus.out), 32'(i));
      step(0, 8'h00, 1);
    end
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0);
    step(1, 8'h55, 1);
    chk("req033_count", 32'(bus.count), 32'd8);
    chk("req033_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1);
    chk("req033_last", 32'(bus.out), 32'h55);
    step(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1);
    chk("req034_count", 32'(bus.count), 32'd1);
    chk("req034_out", 32'(bus.out), 32'h53);
    for (int i = 0; i < 7; i++) step(1, 8'(i), 0);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0);
    chk("req035_drop", 32'(bus.drop_cnt), 32'd255);
    chk("req035_ovf", 32'(bus.overflow), 32'd1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
    step(1, 8'h7E, 0);
    chk("req036_out", 32'(bus.out), 32'h7E);
    chk("req036_count", 32'(bus.count), 32'd1);
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 3 : 1;
      step($urandom_range(0, 3) < bias, 8'($urandom), $urandom_range(0, 3) >= bias);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_capture_fifo.md
DATA_CAPTURE_FIFO -- requirements
Module: data_capture_fifo

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the data width of data and out.
REQ-002: Parameter DEPTH, default 8, SHALL set the number of storage entries; legal values are powers of two, 2 or greater.
REQ-003: clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005: enable, input, 1 bit, SHALL be the write qualifier from the upstream interface stage.
REQ-006: data, input, WIDTH bits, SHALL be the write data, sampled only when enable=1.
REQ-007: out, output, WIDTH bits, SHALL present the head (oldest) entry.
REQ-008: out_valid, output, 1 bit, SHALL indicate that out holds a valid entry.
REQ-009: out_ready, input, 1 bit, SHALL be the downstream accept signal.
REQ-010: full, output, 1 bit, SHALL assert when count equals DEPTH.
REQ-011: empty, output, 1 bit, SHALL assert when count equals 0.
REQ-012: count, output, $clog2(DEPTH)+1 bits, SHALL give the current occupancy, 0 to DEPTH.
REQ-013: drop_cnt, output, 8 bits, SHALL count rejected writes.
REQ-014: overflow, output, 1 bit, SHALL pulse for one cycle on each rejected write.

Function
REQ-015: pop SHALL be defined as out_valid and out_ready; push SHALL be defined as enable and (not full or pop).
REQ-016: On push, data SHALL be written at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-017: On pop, the read pointer SHALL increment modulo DEPTH.
REQ-018: count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019: out_valid SHALL equal not empty; out SHALL be the head entry (show-ahead) when out_valid=1, and all zeros when empty.
REQ-020: Latency SHALL be one cycle: data pushed at edge N into an empty FIFO appears on out with out_valid=1 after edge N.
REQ-021: Write to an empty FIFO: no pop occurs in that cycle, because out_valid=0.
REQ-022: Full with enable=1 and pop=1 in the same cycle: the write SHALL be accepted, and count SHALL stay at DEPTH.
REQ-023: Full with enable=1 and pop=0: the write SHALL be dropped, storage and pointers SHALL be unchanged, overflow SHALL be 1 for the following cycle, and drop_cnt SHALL increment.
REQ-024: drop_cnt SHALL saturate at 255 and never wrap; overflow SHALL still pulse while drop_cnt is saturated.
REQ-025: out_ready=1 while empty SHALL have no effect.
REQ-026: Read and write pointer wrap SHALL be seamless; FIFO ordering SHALL be preserved across wrap.
REQ-027: Data SHALL be stored exactly as received, with no width change and no truncation.

Reset
REQ-028: rst=1 SHALL immediately, without waiting for a clock, clear the pointers, count, drop_cnt and overflow, and SHALL force empty=1, full=0, out_valid=0 and out=0.
REQ-029: Reset asserted mid-operation SHALL discard all stored entries; the storage array need not be cleared.
REQ-030: The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031: Reset, then push 0x11, 0x22, 0x33 with out_ready=0 -> count=3, out=0x11, out_valid=1.
REQ-032: Push 8 values 0x01..0x08, then push 0xAA with out_ready=0 -> full=1, 0xAA dropped, overflow pulses once, drop_cnt=1; draining yields 0x01..0x08 in order.
REQ-033: While full, drive enable=1 with data=0x55 and out_ready=1 -> 0x01 popped, 0x55 accepted, count stays 8, no overflow; 0x55 emerges last.
REQ-034: Stream 20 values with enable=1 and out_ready=1 continuously -> out sequence matches input delayed one cycle, count never exceeds 1, pointers wrap correctly.
REQ-035: Fill to 8, then issue 300 rejected writes -> drop_cnt=255, overflow asserted in each of those cycles.
REQ-036: Assert rst asynchronously between clock edges with count=5 -> outputs clear before the next edge; push 0x7E afterwards -> out=0x7E, count=1.
